// File: rtl/bist_scheduler.sv
// bist_scheduler: runs selected SRAM BIST engines in order, enforces timeouts, logs failing addresses
module bist_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_ENG = 4,
  parameter int LOG_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_ENG-1:0]            alg_mask,
  output logic [NUM_ENG-1:0]            eng_start,
  input  logic [NUM_ENG-1:0]            eng_done,
  input  logic [NUM_ENG-1:0]            eng_fail,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_fail_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [1:0]                    cur_eng,
  output logic [7:0]                    fail_count,
  output logic [NUM_ENG-1:0]            timeout_mask,
  output logic                          log_valid,
  output logic [ADDR_WIDTH-1:0]         log_addr,
  output logic [1:0]                    log_eng,
  input  logic                          log_rd,
  output logic                          log_overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(LOG_DEPTH);
  typedef enum logic [2:0] {IDLE, SELECT, RUN, GAP, DONE} state_t;
  state_t state, state_nx;
  logic [NUM_ENG-1:0] mask_rem;
  logic [TW-1:0] tcnt;
  logic [1:0] low_idx;
  logic [ADDR_WIDTH+1:0] mem [LOG_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic accept, in_run, cur_done, tlast, push, pop, full, wr;
  assign accept = start && (state == IDLE || state == DONE);
  assign in_run = state == RUN;
  assign cur_done = eng_done[cur_eng];
  assign tlast = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign push = in_run && eng_fail[cur_eng];
  assign pop = log_rd && log_valid;
  assign full = cnt == (PW+1)'(LOG_DEPTH);
  assign wr = push && (!full || pop);
  // lowest engine still waiting to run
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) if (mask_rem[i]) low_idx = i[1:0];
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next-state: one engine per SELECT/RUN/GAP round, DONE once the mask is exhausted
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? SELECT : state;
      SELECT:     state_nx = mask_rem == '0 ? DONE : RUN;
      RUN:        state_nx = cur_done || tlast ? GAP : RUN;
      GAP:        state_nx = SELECT;
      default:    state_nx = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    eng_start = in_run ? NUM_ENG'(1) << cur_eng : '0;
    busy = state == SELECT || in_run || state == GAP;
    done = state == DONE;
    pass = done && fail_count == '0 && timeout_mask == '0;
  end
  // run bookkeeping: engine pick, timeout counter, fail/timeout summaries
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_rem <= '0;
      cur_eng <= '0;
      tcnt <= '0;
      fail_count <= '0;
      timeout_mask <= '0;
    end else if (accept) begin
      mask_rem <= alg_mask;
      fail_count <= '0;
      timeout_mask <= '0;
    end else begin
      if (state == SELECT && mask_rem != '0) begin
        cur_eng <= low_idx;
        mask_rem <= mask_rem & (mask_rem - 1'b1);
      end
      tcnt <= in_run ? tcnt + 1'b1 : '0;
      if (in_run && tlast && !cur_done) timeout_mask[cur_eng] <= 1'b1;
      if (push && fail_count != 8'hff) fail_count <= fail_count + 1'b1;
    end
  end
  // fail-log storage; a simultaneous pop frees the slot so a push into a full log still lands
  always_ff @(posedge clk) if (wr) mem[wp] <= {cur_eng, eng_fail_addr[cur_eng*ADDR_WIDTH +: ADDR_WIDTH]};
  // fail-log pointers and overflow flag, wiped by reset or a new run
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (PW+1)'(wr) - (PW+1)'(pop);
      if (push && full && !pop) log_overflow <= 1'b1;
    end
  end
  // head of the log, zeroed when empty
  always_comb begin
    log_valid = cnt != '0;
    log_addr = log_valid ? mem[rp][ADDR_WIDTH-1:0] : '0;
    log_eng = log_valid ? mem[rp][ADDR_WIDTH +: 2] : '0;
  end
endmodule

// File: doc/bist_scheduler.md
Name: bist_scheduler

Overview:
- Top-level sequencer for the 256x4 SRAM BIST subsystem.
- Runs any subset of the four BIST engines (0=BL, 1=CH, 2=MC, 3=MA) one after another on the shared SRAM, in ascending index order.
- Drives each engine's start, watches its done and fail outputs, enforces a per-engine timeout, and logs failing addresses in a small FIFO that software or the bench can read.
- Status outputs summarise the whole run.

Parameters:
- ADDR_WIDTH, 8, SRAM address width (matches SRAM_ADDR_WIDTH).
- NUM_ENG, 4, number of BIST engines; index equals algorithm code.
- LOG_DEPTH, 8, fail-log FIFO depth; power of 2.
- TIMEOUT_CYCLES, 8192, maximum cycles an engine may run before it is aborted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- alg_mask  in  NUM_ENG  engines to run; latched when start is accepted.
- eng_start  out  NUM_ENG  level start to each engine; at most one bit high.
- eng_done  in  NUM_ENG  per-engine completion (controller reached DONE).
- eng_fail  in  NUM_ENG  per-engine fail strobe, one cycle per failing read.
- eng_fail_addr  in  NUM_ENG*ADDR_WIDTH  per-engine fail address; engine i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- busy  out  1  a run is in progress.
- done  out  1  run complete; level.
- pass  out  1  valid while done=1: no fails and no timeouts.
- cur_eng  out  2  index of the engine being run.
- fail_count  out  8  total fail strobes this run; saturates at 255.
- timeout_mask  out  NUM_ENG  sticky; bit i set if engine i timed out.
- log_valid  out  1  fail-log FIFO is non-empty.
- log_addr  out  ADDR_WIDTH  head entry: fail address.
- log_eng  out  2  head entry: engine index.
- log_rd  in  1  pops the head when log_valid=1.
- log_overflow  out  1  sticky; a fail was dropped because the log was full.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, timeout counter 0. A reset mid-run deasserts eng_start on the next edge and discards all results.
- States: IDLE, SELECT, RUN, GAP, DONE.
- IDLE or DONE, start=1:
  - latch alg_mask;
  - clear fail_count, timeout_mask, log_overflow and FIFO;
  - done<=0, busy<=1, go to SELECT.
- start is ignored in SELECT, RUN and GAP.
- SELECT (1 cycle):
  - cur_eng <= lowest set bit of the remaining mask, clear that bit, go to RUN;
  - if no bits remain, go to DONE;
  - alg_mask=0 therefore reaches DONE with pass=1, and no eng_start is ever raised.
- RUN:
  - eng_start[cur_eng]=1, held;
  - timeout counter increments every cycle from 0;
  - go to GAP when eng_done[cur_eng]=1, or when the counter reaches TIMEOUT_CYCLES-1 (set timeout_mask[cur_eng]);
  - if both occur in the same cycle, done wins and no timeout is recorded.
- GAP (1 cycle): eng_start all 0, counter cleared, go to SELECT. This guarantees at least one low cycle between engines.
- DONE:
  - busy=0, done=1;
  - pass = (fail_count==0) && (timeout_mask==0).
- Fail capture, RUN only, eng_fail[cur_eng]=1:
  - fail_count increments, saturating at 255;
  - push {cur_eng, eng_fail_addr slice} into the FIFO.
- Fail and done inputs of non-current engines, and any fail outside RUN, are ignored.
- A fail in the same cycle as done/timeout is still captured.
- FIFO push with the FIFO full and no pop: entry dropped, log_overflow<=1, fail_count still increments.
- FIFO push and pop in the same cycle: both succeed, including when full; no overflow.
- Pop when empty: no effect.
- Pushes are visible on log_valid/log_addr the cycle after the push (registered). log_addr/log_eng are 0 when the FIFO is empty.
- The FIFO is readable in any state. It is cleared only by rst or by a new accepted start.

Test Plan:
- alg_mask=4'b1111, engines model done after 100 cycles, no fails:
  - eng_start bits 0,1,2,3 high in turn, each followed by one GAP low cycle;
  - done=1, pass=1, fail_count=0, log_valid=0.
- alg_mask=4'b0100, engine 2 strobes fail at addr 8'h1A and 8'h80:
  - FIFO pops {2,1A} then {2,80};
  - fail_count=2, pass=0, eng_start[0,1,3] never high.
- alg_mask=4'b0001, engine 0 never asserts done:
  - eng_start[0] drops after exactly TIMEOUT_CYCLES cycles;
  - timeout_mask=4'b0001, pass=0, done=1.
- 10 fails with no reads (LOG_DEPTH=8):
  - 8 entries kept, log_overflow=1, fail_count=10.
- Repeat with log_rd held high: all 10 entries popped, log_overflow=0.
- rst asserted mid-RUN of engine 1:
  - next cycle eng_start=0, busy=0, done=0, log empty;
  - a new start with alg_mask=0 gives done=1, pass=1 after 2 cycles.
- start pulsed during RUN: ignored, engine order and timing unchanged.
- eng_fail from a non-current engine: not logged, fail_count unchanged.
